// File: rtl/control_hazard_unit.sv
// control_hazard_unit
//   Control-hazard controller for the RV32IM pipeline. Detects taken control
//   transfers resolved in EX (JAL/JALR and taken branches). On a transfer it:
//   - flushes the front-end pipeline registers;
//   - redirects the PC, holding the redirect while instruction memory is busy;
//   - squashes IF/ID for FETCH_LATENCY cycles while wrong-path fetches drain.
//   It also keeps a saturating count of redirects.
//
// Ports
//   CLK, RESET        clock (rising edge), asynchronous active-high reset
//   EX_VALID          EX stage holds a valid instruction
//   JUMP              EX instruction is JAL/JALR
//   BRANCH            EX instruction is a conditional branch
//   BRANCH_TAKEN      branch condition true (ignored unless BRANCH)
//   TARGET_PC         resolved target from EX
//   IMEM_BUSY         fetch cannot accept a new PC this cycle
//   FLUSH             per-stage flush; bit 0 = IF/ID, bit 1 = ID/EX, ...
//   PC_SEL            PC mux selects REDIRECT_PC
//   REDIRECT_PC       redirect target
//   FLUSH_ACTIVE      a redirect is being detected or serviced
//   REDIRECT_COUNT    saturating count of detected redirects

module control_hazard_unit #(
    parameter int unsigned NUM_STAGES    = 2,
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned FETCH_LATENCY = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EX_VALID,
    input  logic                  JUMP,
    input  logic                  BRANCH,
    input  logic                  BRANCH_TAKEN,
    input  logic [PC_WIDTH-1:0]   TARGET_PC,
    input  logic                  IMEM_BUSY,
    output logic [NUM_STAGES-1:0] FLUSH,
    output logic                  PC_SEL,
    output logic [PC_WIDTH-1:0]   REDIRECT_PC,
    output logic                  FLUSH_ACTIVE,
    output logic [CNT_WIDTH-1:0]  REDIRECT_COUNT
);

    typedef enum logic [1:0] {StIdle, StHold, StDrain} state_e;

    localparam logic [3:0]            DrainInit = 4'(FETCH_LATENCY);
    localparam logic [NUM_STAGES-1:0] FlushAll  = '1;
    localparam logic [NUM_STAGES-1:0] FlushIfId = NUM_STAGES'(1);
    localparam logic [CNT_WIDTH-1:0]  CntMax    = '1;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
    logic [3:0]            drain_cnt_q, drain_cnt_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  req;

    // Masking with RESET forces all outputs to zero while reset is held,
    // even if a request is presented on the inputs.
    assign req = ~RESET & EX_VALID & (JUMP | (BRANCH & BRANCH_TAKEN));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            pend_pc_q   <= '0;
            drain_cnt_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            drain_cnt_q <= drain_cnt_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        drain_cnt_d = drain_cnt_q;
        count_d     = count_q;
        FLUSH       = '0;
        PC_SEL      = 1'b0;
        REDIRECT_PC = pend_pc_q;

        if (req) begin
            // A new redirect always wins over any sequence in progress.
            FLUSH       = FlushAll;
            PC_SEL      = 1'b1;
            REDIRECT_PC = TARGET_PC;
            pend_pc_d   = TARGET_PC;
            count_d     = (count_q == CntMax) ? count_q : count_q + CNT_WIDTH'(1);
            if (IMEM_BUSY) begin
                state_d = StHold;
            end else if (FETCH_LATENCY > 0) begin
                state_d     = StDrain;
                drain_cnt_d = DrainInit;
            end else begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StHold: begin
                    PC_SEL = 1'b1;
                    FLUSH  = FlushIfId;
                    if (!IMEM_BUSY) begin
                        // Redirect accepted by fetch this cycle.
                        if (FETCH_LATENCY > 0) begin
                            state_d     = StDrain;
                            drain_cnt_d = DrainInit;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDrain: begin
                    FLUSH       = FlushIfId;
                    drain_cnt_d = drain_cnt_q - 4'd1;
                    if (drain_cnt_q <= 4'd1) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign FLUSH_ACTIVE   = req | (state_q != StIdle);
    assign REDIRECT_COUNT = count_q;

endmodule

// File: tb/tb_control_hazard_unit.sv
module tb_control_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, jump, branch, taken, busy;
    logic [31:0] target;
    logic [1:0]  flush;
    logic        pc_sel, active;
    logic [31:0] redirect_pc;
    logic [15:0] count;

    // Second instance: NUM_STAGES=3, FETCH_LATENCY=0, CNT_WIDTH=2
    logic        b_ex_valid, b_jump, b_branch, b_taken, b_busy;
    logic [31:0] b_target;
    logic [2:0]  b_flush;
    logic        b_pc_sel, b_active;
    logic [31:0] b_redirect_pc;
    logic [1:0]  b_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    control_hazard_unit dut (
        .CLK(clk), .RESET(rst), .EX_VALID(ex_valid), .JUMP(jump), .BRANCH(branch),
        .BRANCH_TAKEN(taken), .TARGET_PC(target), .IMEM_BUSY(busy), .FLUSH(flush),
        .PC_SEL(pc_sel), .REDIRECT_PC(redirect_pc), .FLUSH_ACTIVE(active),
        .REDIRECT_COUNT(count)
    );

    control_hazard_unit #(
        .NUM_STAGES(3), .PC_WIDTH(32), .FETCH_LATENCY(0), .CNT_WIDTH(2)
    ) dut2 (
        .CLK(clk), .RESET(rst), .EX_VALID(b_ex_valid), .JUMP(b_jump), .BRANCH(b_branch),
        .BRANCH_TAKEN(b_taken), .TARGET_PC(b_target), .IMEM_BUSY(b_busy), .FLUSH(b_flush),
        .PC_SEL(b_pc_sel), .REDIRECT_PC(b_redirect_pc), .FLUSH_ACTIVE(b_active),
        .REDIRECT_COUNT(b_count)
    );

    typedef struct {
        logic        rst, ev, jmp, br, tk;
        logic [31:0] tgt;
        logic        busy;
        logic [1:0]  e_flush;
        logic        e_sel;
        logic [31:0] e_pc;
        logic        e_act;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic r, input logic ev, input logic j,
                           input logic br, input logic tk, input logic [31:0] tgt,
                           input logic bz, input logic [1:0] fl, input logic sel,
                           input logic [31:0] pc, input logic act, input logic [15:0] cnt);
        vecs[i].rst = r;   vecs[i].ev = ev;   vecs[i].jmp = j;   vecs[i].br = br;
        vecs[i].tk = tk;   vecs[i].tgt = tgt; vecs[i].busy = bz;
        vecs[i].e_flush = fl; vecs[i].e_sel = sel; vecs[i].e_pc = pc;
        vecs[i].e_act = act;  vecs[i].e_cnt = cnt;
    endtask

    task automatic drive_idle();
        ex_valid = 0; jump = 0; branch = 0; taken = 0; busy = 0; target = '0;
    endtask

    task automatic check_main(input string tag, input logic [1:0] fl, input logic sel,
                              input logic [31:0] pc, input logic act, input logic [15:0] cnt);
        check({tag, ".flush"}, 32'(flush), 32'(fl));
        check({tag, ".pc_sel"}, 32'(pc_sel), 32'(sel));
        check({tag, ".redirect_pc"}, redirect_pc, pc);
        check({tag, ".active"}, 32'(active), 32'(act));
        check({tag, ".count"}, 32'(count), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        b_ex_valid = 0; b_jump = 0; b_branch = 0; b_taken = 0; b_busy = 0; b_target = '0;

        //         i  rst ev j br tk tgt        bz flush sel pc         act cnt
        set_vec( 0, 1, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h000, 0, 0);
        // Jump with FETCH_LATENCY=1
        set_vec( 1, 0, 1, 1, 0, 0, 32'h100, 0, 2'b11, 1, 32'h100, 1, 0);
        set_vec( 2, 0, 0, 0, 0, 0, 32'h000, 0, 2'b01, 0, 32'h100, 1, 1);
        set_vec( 3, 0, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h100, 0, 1);
        // Taken branch, fetch busy for three cycles
        set_vec( 4, 0, 1, 0, 1, 1, 32'h200, 1, 2'b11, 1, 32'h200, 1, 1);
        set_vec( 5, 0, 0, 0, 0, 0, 32'h000, 1, 2'b01, 1, 32'h200, 1, 2);
        set_vec( 6, 0, 0, 0, 0, 0, 32'h000, 1, 2'b01, 1, 32'h200, 1, 2);
        set_vec( 7, 0, 0, 0, 0, 0, 32'h000, 0, 2'b01, 1, 32'h200, 1, 2);
        set_vec( 8, 0, 0, 0, 0, 0, 32'h000, 0, 2'b01, 0, 32'h200, 1, 2);
        set_vec( 9, 0, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h200, 0, 2);
        // Second jump overrides HOLD
        set_vec(10, 0, 1, 0, 1, 1, 32'h200, 1, 2'b11, 1, 32'h200, 1, 2);
        set_vec(11, 0, 1, 1, 0, 0, 32'h300, 1, 2'b11, 1, 32'h300, 1, 3);
        set_vec(12, 0, 0, 0, 0, 0, 32'h000, 0, 2'b01, 1, 32'h300, 1, 4);
        set_vec(13, 0, 0, 0, 0, 0, 32'h000, 0, 2'b01, 0, 32'h300, 1, 4);
        set_vec(14, 0, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h300, 0, 4);
        // Non-events: untaken branch, invalid jump
        set_vec(15, 0, 1, 0, 1, 0, 32'h400, 0, 2'b00, 0, 32'h300, 0, 4);
        set_vec(16, 0, 0, 1, 0, 0, 32'h500, 0, 2'b00, 0, 32'h300, 0, 4);
        set_vec(17, 0, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h300, 0, 4);
        // Untaken branch during DRAIN leaves the sequence alone
        set_vec(18, 0, 1, 1, 0, 0, 32'h600, 0, 2'b11, 1, 32'h600, 1, 4);
        set_vec(19, 0, 1, 0, 1, 0, 32'h700, 0, 2'b01, 0, 32'h600, 1, 5);
        set_vec(20, 0, 0, 0, 0, 0, 32'h000, 0, 2'b00, 0, 32'h600, 0, 5);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; ex_valid = vecs[i].ev; jump = vecs[i].jmp;
            branch = vecs[i].br; taken = vecs[i].tk; target = vecs[i].tgt;
            busy = vecs[i].busy;
            #1;
            check_main($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_sel,
                       vecs[i].e_pc, vecs[i].e_act, vecs[i].e_cnt);
        end

        // Saturation and FETCH_LATENCY=0 on the second instance.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_ex_valid = 1; b_jump = 1; b_target = 32'h1000 + 32'(i);
            #1;
            check($sformatf("sat%0d.flush_req", i), 32'(b_flush), 32'h7);
            check($sformatf("sat%0d.pc_sel_req", i), 32'(b_pc_sel), 32'h1);
            check($sformatf("sat%0d.redirect_req", i), b_redirect_pc, 32'h1000 + 32'(i));
            @(negedge clk);
            b_ex_valid = 0; b_jump = 0; b_target = '0;
            #1;
            check($sformatf("sat%0d.flush_after", i), 32'(b_flush), 32'h0);
            check($sformatf("sat%0d.active_after", i), 32'(b_active), 32'h0);
            check($sformatf("sat%0d.count", i), 32'(b_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Asynchronous reset in the middle of DRAIN.
        @(negedge clk);
        ex_valid = 1; jump = 1; target = 32'h700;
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        check("drain_before_reset.flush", 32'(flush), 32'h1);
        rst = 1'b1;
        #1;
        check_main("reset_mid_drain", 2'b00, 1'b0, 32'h0, 1'b0, 16'h0);
        ex_valid = 1; jump = 1; target = 32'h800;
        #1;
        check_main("reset_with_req", 2'b00, 1'b0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1;
        check_main("reset_release", 2'b00, 1'b0, 32'h0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check_main("after_release_edge", 2'b00, 1'b0, 32'h0, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
